// File: rtl/sam_pkg.sv
// Shared definitions for the SRAM arbiter: bus widths, FSM states and
// the grant encoding produced by the arbitration function.
package sam_pkg;

    localparam int SRAM_AW = 19;
    localparam int SRAM_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } sam_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VID,
        GNT_CPU
    } sam_grant_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one asynchronous byte-wide SRAM between a video
// fetch port and a CPU port. Video has priority but is limited to
// VID_BURST_MAX consecutive grants while the CPU is waiting.
module sram_arbiter
    import sam_pkg::*;
#(
    parameter int VID_BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               vid_req,
    input  logic [SRAM_AW-1:0] vid_addr,
    output logic               vid_ack,
    output logic [SRAM_DW-1:0] vid_data,

    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [SRAM_AW-1:0] cpu_addr,
    input  logic [SRAM_DW-1:0] cpu_din,
    output logic               cpu_ack,
    output logic [SRAM_DW-1:0] cpu_dout,

    output logic [SRAM_AW-1:0] sram_a,
    output logic               sram_we_n,
    output logic [SRAM_DW-1:0] sram_d_out,
    output logic               sram_d_oe,
    input  logic [SRAM_DW-1:0] sram_d_in
);

    localparam int CW = (VID_BURST_MAX < 1) ? 1 : $clog2(VID_BURST_MAX + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(VID_BURST_MAX);

    sam_state_t  state;
    logic        owner_cpu;
    logic [CW-1:0] burst_cnt;

    logic        vid_elig;
    logic        cpu_elig;
    logic        arb_point;
    sam_grant_t  gnt;

    // Video wins contention unless it has used up its burst allowance.
    function automatic sam_grant_t arbitrate(input logic v, input logic c,
                                             input logic burst_full);
        sam_grant_t g;
        g = GNT_NONE;
        if (v && c)
            g = burst_full ? GNT_CPU : GNT_VID;
        else if (v)
            g = GNT_VID;
        else if (c)
            g = GNT_CPU;
        return g;
    endfunction

    // Eligibility and grant decision; a requester whose access completes at
    // this edge is still eligible, since its ack only rises afterwards.
    always_comb begin
        vid_elig  = vid_req && !vid_ack;
        cpu_elig  = cpu_req && !cpu_ack;
        arb_point = (state == IDLE) || (state == RD_DATA) || (state == WR_HOLD);
        gnt       = GNT_NONE;
        if (arb_point)
            gnt = arbitrate(vid_elig, cpu_elig, burst_cnt == BURST_LIMIT);
    end

    // Burst counter: counts video grants made while the CPU waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (!cpu_req || gnt == GNT_CPU) begin
            burst_cnt <= '0;
        end else if (gnt == GNT_VID && burst_cnt != BURST_LIMIT) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Access sequencer: state, registered SRAM pins, read data and acks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner_cpu  <= 1'b0;
            sram_a     <= '0;
            sram_we_n  <= 1'b1;
            sram_d_out <= '0;
            sram_d_oe  <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            vid_data   <= '0;
            cpu_dout   <= '0;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;

            case (state)
                RD_ADDR: state <= RD_DATA;
                RD_DATA: begin
                    if (owner_cpu) begin
                        cpu_dout <= sram_d_in;
                        cpu_ack  <= 1'b1;
                    end else begin
                        vid_data <= sram_d_in;
                        vid_ack  <= 1'b1;
                    end
                end
                WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    sram_we_n <= 1'b1;
                    state     <= WR_HOLD;
                end
                WR_HOLD: cpu_ack <= 1'b1;
                default: ;
            endcase

            // Arbitration states launch the next access directly, so
            // back-to-back accesses need no idle cycle.
            if (arb_point) begin
                case (gnt)
                    GNT_VID: begin
                        owner_cpu <= 1'b0;
                        sram_a    <= vid_addr;
                        sram_we_n <= 1'b1;
                        sram_d_oe <= 1'b0;
                        state     <= RD_ADDR;
                    end
                    GNT_CPU: begin
                        owner_cpu <= 1'b1;
                        sram_a    <= cpu_addr;
                        sram_we_n <= 1'b1;
                        if (cpu_we) begin
                            sram_d_out <= cpu_din;
                            sram_d_oe  <= 1'b1;
                            state      <= WR_SETUP;
                        end else begin
                            sram_d_oe  <= 1'b0;
                            state      <= RD_ADDR;
                        end
                    end
                    default: begin
                        sram_d_oe <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter. The SRAM is modelled as a
// read pattern: byte at address a = a[7:0] ^ 8'hB5.
module tb_sram_arbiter;
    import sam_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                vid_req;
    logic [SRAM_AW-1:0]  vid_addr;
    logic                vid_ack;
    logic [SRAM_DW-1:0]  vid_data;
    logic                cpu_req;
    logic                cpu_we;
    logic [SRAM_AW-1:0]  cpu_addr;
    logic [SRAM_DW-1:0]  cpu_din;
    logic                cpu_ack;
    logic [SRAM_DW-1:0]  cpu_dout;
    logic [SRAM_AW-1:0]  sram_a;
    logic                sram_we_n;
    logic [SRAM_DW-1:0]  sram_d_out;
    logic                sram_d_oe;
    logic [SRAM_DW-1:0]  sram_d_in;

    int checks = 0;
    int errors = 0;

    always #21 clk = ~clk;

    always_comb sram_d_in = sram_a[7:0] ^ 8'hB5;

    sram_arbiter #(.VID_BURST_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_data   (vid_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_ack    (cpu_ack),
        .cpu_dout   (cpu_dout),
        .sram_a     (sram_a),
        .sram_we_n  (sram_we_n),
        .sram_d_out (sram_d_out),
        .sram_d_oe  (sram_d_oe),
        .sram_d_in  (sram_d_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_pins(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] oe, input logic [31:0] we_n);
        chk({tag, "_a"},    32'(sram_a),     a);
        chk({tag, "_dout"}, 32'(sram_d_out), d);
        chk({tag, "_oe"},   32'(sram_d_oe),  oe);
        chk({tag, "_we_n"}, 32'(sram_we_n),  we_n);
    endtask

    // Release all requests and wait for in-flight accesses to finish.
    task automatic drain();
        int quiet = 0;
        vid_req = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        for (int i = 0; i < 30 && quiet < 4; i++) begin
            tick();
            if (vid_ack || cpu_ack) quiet = 0;
            else quiet++;
        end
        chk("drain_quiet", 32'(quiet >= 4), 32'h1);
    endtask

    // Video held continuously, CPU read raised together with it.
    task automatic contention(input string tag, input logic [31:0] exp_dout);
        int nv = 0;
        int post = 0;
        int last = -1;
        bit seen = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            chk({tag, "_ack_excl"}, 32'(vid_ack & cpu_ack), 32'h0);
            if (vid_ack || cpu_ack) begin
                if (last < 0) chk({tag, "_first_ack_cyc"}, 32'(cyc), 32'd3);
                else          chk({tag, "_ack_gap"}, 32'(cyc - last), 32'd2);
                last = cyc;
            end
            if (cpu_ack) begin
                seen    = 1'b1;
                cpu_req = 1'b0;
                chk({tag, "_vid_burst"}, 32'(nv), 32'd4);
                chk({tag, "_cpu_dout"}, 32'(cpu_dout), exp_dout);
            end else if (vid_ack) begin
                if (seen) post++;
                else nv++;
                chk({tag, "_vid_data"}, 32'(vid_data), 32'hA5);
            end
            if (post == 2) break;
        end
        chk({tag, "_done"}, 32'(seen && post == 2), 32'h1);
        drain();
    endtask

    task automatic write_seq(input string tag, input logic [18:0] a, input logic [7:0] d,
                             input logic [31:0] exp_dout);
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        tick();
        chk_pins({tag, "_setup"}, 32'(a), 32'(d), 32'h1, 32'h1);
        chk({tag, "_setup_ack"}, 32'(cpu_ack), 32'h0);
        tick();
        chk_pins({tag, "_pulse"}, 32'(a), 32'(d), 32'h1, 32'h0);
        tick();
        chk_pins({tag, "_hold"}, 32'(a), 32'(d), 32'h1, 32'h1);
        chk({tag, "_hold_ack"}, 32'(cpu_ack), 32'h0);
        tick();
        chk({tag, "_ack"}, 32'(cpu_ack), 32'h1);
        chk({tag, "_vid_ack"}, 32'(vid_ack), 32'h0);
        chk({tag, "_dout_kept"}, 32'(cpu_dout), exp_dout);
        cpu_req = 1'b0;
        tick();
        chk({tag, "_ack_width"}, 32'(cpu_ack), 32'h0);
        drain();
    endtask

    initial begin
        rst      = 1'b1;
        vid_req  = 1'b0;
        vid_addr = '0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        repeat (3) tick();

        // Reset state
        chk_pins("rst", 32'h0, 32'h0, 32'h0, 32'h1);
        chk("rst_vid_ack",  32'(vid_ack),  32'h0);
        chk("rst_cpu_ack",  32'(cpu_ack),  32'h0);
        chk("rst_vid_data", 32'(vid_data), 32'h0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'h0);

        // Video read; request pending across reset release
        vid_req  = 1'b1;
        vid_addr = 19'h00010;
        tick();
        chk("rst_no_grant", 32'(sram_a), 32'h0);
        rst = 1'b0;
        tick();
        chk_pins("vrd_addr", 32'h10, 32'h0, 32'h0, 32'h1);
        chk("vrd_ack0", 32'(vid_ack), 32'h0);
        tick();
        chk("vrd_ack1", 32'(vid_ack), 32'h0);
        chk("vrd_we_n", 32'(sram_we_n), 32'h1);
        tick();
        chk("vrd_ack", 32'(vid_ack), 32'h1);
        chk("vrd_data", 32'(vid_data), 32'hA5);
        chk("vrd_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("vrd_we_n2", 32'(sram_we_n), 32'h1);
        vid_req = 1'b0;
        tick();
        chk("vrd_ack_width", 32'(vid_ack), 32'h0);
        drain();
        chk("vrd_data_held", 32'(vid_data), 32'hA5);

        // Contention: 4 video grants, then the CPU read, then video resumes
        vid_addr = 19'h00010;
        cpu_addr = 19'h00123;
        cpu_we   = 1'b0;
        vid_req  = 1'b1;
        cpu_req  = 1'b1;
        contention("cont1", 32'h96);

        // Burst counter starts again from zero
        vid_addr = 19'h00010;
        cpu_addr = 19'h00155;
        cpu_we   = 1'b0;
        vid_req  = 1'b1;
        cpu_req  = 1'b1;
        contention("cont2", 32'hE0);

        // CPU write at top address; cpu_dout keeps the last read byte
        write_seq("wr", 19'h7FFFF, 8'h3C, 32'hE0);
        chk("wr_vid_data_held", 32'(vid_data), 32'hA5);

        // Reset during WR_PULSE
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 19'h00ABC;
        cpu_din  = 8'hC3;
        tick();
        tick();
        chk("rw_pulse_we_n", 32'(sram_we_n), 32'h0);
        #5 rst = 1'b1;
        #1;
        chk_pins("rw_async", 32'h0, 32'h0, 32'h0, 32'h1);
        chk("rw_async_ack", 32'(cpu_ack), 32'h0);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rw_in_rst_ack", 32'(cpu_ack), 32'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rw_after_ack", 32'(cpu_ack), 32'h0);
            chk("rw_after_we_n", 32'(sram_we_n), 32'h1);
        end
        write_seq("rw_retry", 19'h00ABC, 8'hC3, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter VID_BURST_MAX, default 4: max consecutive video grants while cpu_req is pending.
REQ-002 SHALL have clk (input, 1): single clock, 24 MHz, all logic on rising edge.
REQ-003 SHALL have rst (input, 1): asynchronous, active-high reset.
REQ-004 SHALL have vid_req (input, 1) and vid_addr (input, 19): video fetch request and address.
REQ-005 SHALL have vid_ack (output, 1) and vid_data (output, 8): one-cycle completion pulse and read byte.
REQ-006 SHALL have cpu_req (input, 1), cpu_we (input, 1), cpu_addr (input, 19) and cpu_din (input, 8): CPU request, 1=write, address, write byte.
REQ-007 SHALL have cpu_ack (output, 1) and cpu_dout (output, 8): one-cycle completion pulse and read byte.
REQ-008 SHALL have sram_a (output, 19), sram_we_n (output, 1), sram_d_out (output, 8), sram_d_oe (output, 1) and sram_d_in (input, 8): SRAM pins, with the data bus split; the top level builds the inout pad.

Function
REQ-009 SHALL treat requests as level-held: each requester keeps req, addr, we and din stable until its ack, and drops req in the ack cycle.
REQ-010 SHALL never grant a requester in a cycle where that requester's ack is high.
REQ-011 SHALL implement the states IDLE, RD_ADDR, RD_DATA, WR_SETUP, WR_PULSE and WR_HOLD.
REQ-012 SHALL arbitrate in IDLE, RD_DATA and WR_HOLD, so back-to-back accesses run with no idle cycle.
REQ-013 SHALL give the grant to video when only vid_req is eligible, to the CPU when only cpu_req is eligible, and stay in or go to IDLE when neither is.
REQ-014 SHALL, when both are eligible, grant video unless the burst counter equals VID_BURST_MAX; in that case it grants the CPU.
REQ-015 SHALL increment the burst counter on each video grant made while cpu_req is high, saturating at VID_BURST_MAX, and clear it on any CPU grant or whenever cpu_req is low.
REQ-016 SHALL route video grants and CPU reads to RD_ADDR and CPU writes to WR_SETUP.
REQ-017 SHALL, in RD_ADDR, drive sram_a with the granted address, keep sram_we_n=1 and sram_d_oe=0, then go to RD_DATA.
REQ-018 SHALL, at the RD_DATA clock edge, register sram_d_in into vid_data or cpu_dout and pulse the matching ack for exactly the next cycle. Read latency is grant edge to ack = 2 cycles.
REQ-019 SHALL, in WR_SETUP, drive sram_a=cpu_addr, sram_d_out=cpu_din and sram_d_oe=1, with sram_we_n=1.
REQ-020 SHALL, in WR_PULSE, hold the address and data and drive sram_we_n=0.
REQ-021 SHALL, in WR_HOLD, set sram_we_n=1 while keeping the address, data and oe, and pulse cpu_ack in the next cycle. Write latency = 3 cycles.
REQ-022 SHALL drive all SRAM outputs from registers; sram_a and sram_d_out never change while sram_we_n=0.
REQ-023 SHALL drive sram_d_oe=0 in every state except WR_SETUP, WR_PULSE and WR_HOLD.
REQ-024 SHALL hold vid_data and cpu_dout until their next read completes; CPU writes leave cpu_dout unchanged.
REQ-025 SHALL assert at most one ack per cycle.

Reset
REQ-026 SHALL, while rst is high, force state=IDLE, sram_we_n=1, sram_d_oe=0, sram_a=0, sram_d_out=0, vid_ack=0, cpu_ack=0, vid_data=0, cpu_dout=0 and burst counter=0.
REQ-027 SHALL, on rst mid-write, raise sram_we_n immediately and asynchronously; the aborted access is never acked.
REQ-028 SHALL perform its first arbitration on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL take the state enumeration and SRAM_AW=19 / SRAM_DW=8 from shared package sam_pkg.
REQ-030 SHALL be a single module with no sub-modules; the arbitration decision is a local combinational function.

Verification
REQ-031 Video-only read: vid_addr=19'h00010, SRAM byte 8'hA5 -> vid_ack 2 cycles after grant, vid_data=8'hA5, sram_we_n stays 1.
REQ-032 CPU write: cpu_addr=19'h7FFFF, cpu_din=8'h3C -> sram_we_n low for exactly 1 cycle, address/data stable from WR_SETUP through WR_HOLD, cpu_ack on cycle 3.
REQ-033 Contention: vid_req held continuously, cpu_req raised for a read -> exactly 4 video acks, then cpu_ack; the counter then restarts.
REQ-034 Back-to-back: alternating video/CPU reads -> no IDLE cycle between accesses, and the two acks never coincide.
REQ-035 Reset in WR_PULSE: rst asserted -> sram_we_n=1 and sram_d_oe=0 in the same cycle, no cpu_ack; a re-issued write completes normally.
